// File: rtl/mem_req_arbiter.sv
// Round-robin owner of the shared AXI read/write master: grant + start pulse one cycle after a request is sampled in IDLE,
// ownership held to r_last/b_resp, then a one-cycle o_done; requests are level-held. Optional watchdog: MEM_ARB_TIMEOUT_EN.
module mem_req_arbiter #(
  parameter int N_CH      = 2,
  parameter int CH_W      = $clog2(N_CH),
  parameter int TIMEOUT_W = 8
) (
  input  logic            clk,
  input  logic            arstn,
  input  logic [N_CH-1:0] i_rd_req,
  input  logic [N_CH-1:0] i_wr_req,
  input  logic            i_r_last,
  input  logic            i_b_resp,
  output logic            o_start_read,
  output logic            o_start_write,
  output logic [N_CH-1:0] o_grant,
  output logic [CH_W-1:0] o_grant_id,
  output logic            o_busy,
  output logic [N_CH-1:0] o_done,
  output logic            o_timeout
);

  localparam int CW1 = CH_W + 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  if (N_CH < 2 || TIMEOUT_W < 1) begin : g_bad_params
    $error("mem_req_arbiter: N_CH must be >= 2 and TIMEOUT_W >= 1");
  end

  state_e          state_q, state_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [CH_W-1:0] owner_q, owner_d;
  logic            start_rd_q, start_rd_d;
  logic            start_wr_q, start_wr_d;
  logic [N_CH-1:0] eligible;
  logic            win_found;
  logic [CH_W-1:0] win_idx;
  logic [CW1-1:0]  cand;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 timeout_q, timeout_d;
`endif

  assign eligible = i_rd_req | i_wr_req;

  // Rotating priority: search starts one past the last owner and wraps at N_CH,
  // so indices >= N_CH are never produced even when N_CH is not a power of two.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = {1'b0, ptr_q} + CW1'(i);
      if (cand >= CW1'(N_CH)) cand = cand - CW1'(N_CH);
      if (!win_found && eligible[cand[CH_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    start_rd_d = 1'b0;
    start_wr_d = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    wdog_d     = wdog_q;
    timeout_d  = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          owner_d = win_idx;
          ptr_d   = win_idx;
          // Dirty eviction goes out before the refill; the read stays pending.
          if (i_wr_req[win_idx]) begin
            state_d    = WRITE;
            start_wr_d = 1'b1;
          end else begin
            state_d    = READ;
            start_rd_d = 1'b1;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          wdog_d = '0;
`endif
        end
      end
      READ, WRITE: begin
        if ((state_q == READ && i_r_last) || (state_q == WRITE && i_b_resp)) begin
          state_d = DONE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (wdog_q == '1) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + TIMEOUT_W'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_grant = '0;
    o_done  = '0;
    if (state_q == READ || state_q == WRITE) o_grant[owner_q] = 1'b1;
    if (state_q == DONE) o_done[owner_q] = 1'b1;
  end

  assign o_start_read  = start_rd_q;
  assign o_start_write = start_wr_q;
  assign o_grant_id    = owner_q;
  assign o_busy        = (state_q != IDLE);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= IDLE;
      ptr_q      <= CH_W'(N_CH - 1);
      owner_q    <= '0;
      start_rd_q <= 1'b0;
      start_wr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      start_rd_q <= start_rd_d;
      start_wr_q <= start_wr_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter with three channels and a 4-bit watchdog (exercised when MEM_ARB_TIMEOUT_EN is defined).
// Grants and completions are scoreboarded in order; cycle-exact latencies are checked inside each scenario.
module tb_mem_req_arbiter;
  localparam int N_CH = 3;
  localparam int CH_W = 2;
  localparam int TW   = 4;

  // kind: 2'b01 read start, 2'b10 write start, 2'b00 done. aux: o_busy at start, |o_grant at done.
  typedef struct packed {
    logic [1:0]      kind;
    logic [N_CH-1:0] vec;
    logic            aux;
  } ev_t;

  logic            clk = 1'b0;
  logic            arstn;
  logic [N_CH-1:0] rd_req, wr_req;
  logic            r_last, b_resp;
  logic            o_start_read, o_start_write, o_busy, o_timeout;
  logic [N_CH-1:0] o_grant, o_done;
  logic [CH_W-1:0] o_grant_id;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  obs_rd   = 0;
  int  n_checks = 0;
  int  n_pass   = 0;
  int  mptr     = N_CH - 1;

  mem_req_arbiter #(.N_CH(N_CH), .CH_W(CH_W), .TIMEOUT_W(TW)) dut (
    .clk(clk), .arstn(arstn), .i_rd_req(rd_req), .i_wr_req(wr_req),
    .i_r_last(r_last), .i_b_resp(b_resp), .o_start_read(o_start_read),
    .o_start_write(o_start_write), .o_grant(o_grant), .o_grant_id(o_grant_id),
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (arstn) begin
      if (o_start_read || o_start_write) obs_q.push_back({o_start_write, o_start_read, o_grant, o_busy});
      else if (o_done != '0) obs_q.push_back({2'b00, o_done, |o_grant});
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "time limit");
  end

  function automatic int rr_pick(int ptr, logic [N_CH-1:0] el);
    for (int i = 1; i <= N_CH; i++) if (el[(ptr + i) % N_CH]) return (ptr + i) % N_CH;
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_start(input int ch, input logic wr);
    ev_t e;
    e.kind = wr ? 2'b10 : 2'b01;
    e.vec  = N_CH'(1 << ch);
    e.aux  = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int ch);
    ev_t e;
    e.kind = 2'b00;
    e.vec  = N_CH'(1 << ch);
    e.aux  = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic pulse_rlast();
    r_last = 1'b1;
    tick(1);
    r_last = 1'b0;
  endtask

  task automatic pulse_bresp();
    b_resp = 1'b1;
    tick(1);
    b_resp = 1'b0;
  endtask

  task automatic test_reset();
    tick(2);
    n_checks++;
    if ({o_start_read, o_start_write, o_grant, o_grant_id, o_busy, o_done, o_timeout} !== 12'b0)
      $display("FAIL reset_outputs: got sr=%b sw=%b grant=%b id=%0d busy=%b done=%b to=%b, required all 0",
               o_start_read, o_start_write, o_grant, o_grant_id, o_busy, o_done, o_timeout);
    else n_pass++;
    arstn = 1'b1;
    tick(2);
    n_checks++;
    if (o_busy !== 1'b0 || o_grant !== '0) $display("FAIL reset_idle: busy=%b grant=%b, required 0/000", o_busy, o_grant);
    else n_pass++;
  endtask

  task automatic test_single_read();
    ev_t e;
    rd_req = 3'b001;
    mptr = rr_pick(mptr, rd_req);
    push_start(mptr, 1'b0);
    tick(1);
    n_checks++;
    if ({o_start_read, o_start_write, o_grant, o_busy} !== {1'b1, 1'b0, 3'b001, 1'b1})
      $display("FAIL single_start: sr=%b sw=%b grant=%b busy=%b, required 1 0 001 1", o_start_read, o_start_write, o_grant, o_busy);
    else n_pass++;
    tick(4);
    n_checks++;
    if (o_start_read !== 1'b0 || o_grant !== 3'b001)
      $display("FAIL single_hold: sr=%b grant=%b, required 0 001", o_start_read, o_grant);
    else n_pass++;
    pulse_rlast();
    push_done(0);
    n_checks++;
    if (o_done !== 3'b001 || o_grant !== 3'b000 || o_busy !== 1'b1)
      $display("FAIL single_done: done=%b grant=%b busy=%b, required 001 000 1", o_done, o_grant, o_busy);
    else n_pass++;
    rd_req = 3'b000;
    tick(1);
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 3'b000 || o_grant_id !== 2'd0)
      $display("FAIL single_idle: busy=%b done=%b id=%0d, required 0 000 0", o_busy, o_done, o_grant_id);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_rd >= obs_q.size()) $display("FAIL single_sb: no event observed, required %b", e);
      else begin
        if (obs_q[obs_rd] !== e) $display("FAIL single_sb: observed %b, required %b", obs_q[obs_rd], e);
        else n_pass++;
        obs_rd++;
      end
    end
  endtask

  task automatic test_round_robin();
    int  exp_ch;
    int  k;
    ev_t e;
    rd_req = 3'b011;
    for (int b = 0; b < 7; b++) begin
      exp_ch = rr_pick(mptr, rd_req);
      mptr = exp_ch;
      push_start(exp_ch, 1'b0);
      k = 0;
      while (!(o_start_read || o_start_write) && k < 8) begin
        tick(1);
        k++;
      end
      n_checks++;
      if (o_start_read !== 1'b1 || o_grant !== N_CH'(1 << exp_ch))
        $display("FAIL rr_grant: burst %0d sr=%b grant=%b, required 1 %b", b, o_start_read, o_grant, N_CH'(1 << exp_ch));
      else n_pass++;
      tick(2);
      pulse_rlast();
      push_done(exp_ch);
      if (b == 3) rd_req = 3'b111;
      if (b == 6) rd_req = 3'b000;
    end
    tick(1);
    n_checks++;
    if (o_grant_id !== CH_W'(mptr) || o_timeout !== 1'b0)
      $display("FAIL rr_last_owner: id=%0d timeout=%b, required %0d 0", o_grant_id, o_timeout, mptr);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_rd >= obs_q.size()) $display("FAIL rr_sb: no event observed, required %b", e);
      else begin
        if (obs_q[obs_rd] !== e) $display("FAIL rr_sb: observed %b, required %b", obs_q[obs_rd], e);
        else n_pass++;
        obs_rd++;
      end
    end
  endtask

  task automatic test_write_before_read();
    int  k;
    ev_t e;
    rd_req = 3'b010;
    wr_req = 3'b010;
    mptr = rr_pick(mptr, rd_req | wr_req);
    push_start(mptr, 1'b1);
    tick(1);
    n_checks++;
    if ({o_start_write, o_start_read, o_grant} !== {1'b1, 1'b0, 3'b010})
      $display("FAIL wbr_write_first: sw=%b sr=%b grant=%b, required 1 0 010", o_start_write, o_start_read, o_grant);
    else n_pass++;
    tick(2);
    pulse_bresp();
    push_done(1);
    n_checks++;
    if (o_done !== 3'b010 || o_grant !== 3'b000)
      $display("FAIL wbr_write_done: done=%b grant=%b, required 010 000", o_done, o_grant);
    else n_pass++;
    wr_req = 3'b000;
    mptr = rr_pick(mptr, rd_req);
    push_start(mptr, 1'b0);
    k = 0;
    while (!(o_start_read || o_start_write) && k < 8) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (o_start_read !== 1'b1 || o_grant !== 3'b010)
      $display("FAIL wbr_read_next: sr=%b grant=%b, required 1 010", o_start_read, o_grant);
    else n_pass++;
    tick(1);
    pulse_rlast();
    push_done(1);
    rd_req = 3'b000;
    tick(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_rd >= obs_q.size()) $display("FAIL wbr_sb: no event observed, required %b", e);
      else begin
        if (obs_q[obs_rd] !== e) $display("FAIL wbr_sb: observed %b, required %b", obs_q[obs_rd], e);
        else n_pass++;
        obs_rd++;
      end
    end
  endtask

  task automatic test_spurious();
    ev_t e;
    rd_req = 3'b100;
    mptr = rr_pick(mptr, rd_req);
    push_start(mptr, 1'b0);
    tick(2);
    b_resp = 1'b1;
    tick(1);
    b_resp = 1'b0;
    tick(1);
    n_checks++;
    if (o_busy !== 1'b1 || o_grant !== 3'b100 || o_done !== 3'b000)
      $display("FAIL spur_bresp_in_read: busy=%b grant=%b done=%b, required 1 100 000", o_busy, o_grant, o_done);
    else n_pass++;
    pulse_rlast();
    push_done(2);
    n_checks++;
    if (o_done !== 3'b100 || o_grant !== 3'b000 || o_start_read !== 1'b0)
      $display("FAIL spur_done_held: done=%b grant=%b sr=%b, required 100 000 0", o_done, o_grant, o_start_read);
    else n_pass++;
    tick(1);
    n_checks++;
    if (o_busy !== 1'b0 || o_grant !== 3'b000 || o_start_read !== 1'b0 || o_grant_id !== 2'd2)
      $display("FAIL spur_no_regrant: busy=%b grant=%b sr=%b id=%0d, required 0 000 0 2", o_busy, o_grant, o_start_read, o_grant_id);
    else n_pass++;
    rd_req = 3'b000;
    tick(1);
    r_last = 1'b1;
    tick(1);
    r_last = 1'b0;
    tick(1);
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 3'b000)
      $display("FAIL spur_rlast_idle: busy=%b done=%b, required 0 000", o_busy, o_done);
    else n_pass++;
    wr_req = 3'b001;
    mptr = rr_pick(mptr, wr_req);
    push_start(mptr, 1'b1);
    tick(2);
    r_last = 1'b1;
    tick(1);
    r_last = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1 || o_grant !== 3'b001 || o_done !== 3'b000)
      $display("FAIL spur_rlast_in_write: busy=%b grant=%b done=%b, required 1 001 000", o_busy, o_grant, o_done);
    else n_pass++;
    r_last = 1'b1;
    b_resp = 1'b1;
    tick(1);
    r_last = 1'b0;
    b_resp = 1'b0;
    push_done(0);
    n_checks++;
    if (o_done !== 3'b001) $display("FAIL spur_both_in_write: done=%b, required 001", o_done);
    else n_pass++;
    wr_req = 3'b000;
    tick(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_rd >= obs_q.size()) $display("FAIL spur_sb: no event observed, required %b", e);
      else begin
        if (obs_q[obs_rd] !== e) $display("FAIL spur_sb: observed %b, required %b", obs_q[obs_rd], e);
        else n_pass++;
        obs_rd++;
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    ev_t e;
    wr_req = 3'b010;
    mptr = rr_pick(mptr, wr_req);
    push_start(mptr, 1'b1);
    tick(3);
    #2;
    arstn  = 1'b0;
    wr_req = 3'b000;
    #1;
    n_checks++;
    if ({o_start_read, o_start_write, o_grant, o_grant_id, o_busy, o_done, o_timeout} !== 12'b0)
      $display("FAIL rst_mid_outputs: sr=%b sw=%b grant=%b id=%0d busy=%b done=%b to=%b, required all 0",
               o_start_read, o_start_write, o_grant, o_grant_id, o_busy, o_done, o_timeout);
    else n_pass++;
    tick(2);
    arstn = 1'b1;
    mptr = N_CH - 1;
    rd_req = 3'b011;
    mptr = rr_pick(mptr, rd_req);
    push_start(mptr, 1'b0);
    tick(1);
    n_checks++;
    if (o_start_read !== 1'b1 || o_grant !== 3'b001)
      $display("FAIL rst_mid_ptr: sr=%b grant=%b, required 1 001", o_start_read, o_grant);
    else n_pass++;
    tick(1);
    pulse_rlast();
    push_done(0);
    rd_req = 3'b000;
    tick(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_rd >= obs_q.size()) $display("FAIL rst_sb: no event observed, required %b", e);
      else begin
        if (obs_q[obs_rd] !== e) $display("FAIL rst_sb: observed %b, required %b", obs_q[obs_rd], e);
        else n_pass++;
        obs_rd++;
      end
    end
    n_checks++;
    if (obs_rd != obs_q.size()) $display("FAIL sb_extra: %0d unexpected events, required 0", obs_q.size() - obs_rd);
    else n_pass++;
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    rd_req = 3'b001;
    tick(1);
    n_checks++;
    if (o_start_read !== 1'b1 || o_grant !== 3'b001)
      $display("FAIL to_start: sr=%b grant=%b, required 1 001", o_start_read, o_grant);
    else n_pass++;
    k = 0;
    while (o_done === 3'b000 && k < 40) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (k !== (1 << TW) || o_done !== 3'b001 || o_timeout !== 1'b1)
      $display("FAIL to_forced_done: cycles=%0d done=%b timeout=%b, required %0d 001 1", k, o_done, o_timeout, 1 << TW);
    else n_pass++;
    rd_req = 3'b000;
    tick(3);
    n_checks++;
    if (o_timeout !== 1'b1 || o_busy !== 1'b0)
      $display("FAIL to_sticky: timeout=%b busy=%b, required 1 0", o_timeout, o_busy);
    else n_pass++;
    arstn = 1'b0;
    #1;
    n_checks++;
    if (o_timeout !== 1'b0) $display("FAIL to_reset_clear: timeout=%b, required 0", o_timeout);
    else n_pass++;
    tick(1);
    arstn = 1'b1;
  endtask
`endif

  initial begin
    arstn  = 1'b0;
    rd_req = '0;
    wr_req = '0;
    r_last = 1'b0;
    b_resp = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_before_read();
    test_spurious();
    test_reset_mid_burst();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
